// File: rtl/avm_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avm_sram_pkg
// Description : Shared widths, command record and FSM states for the
//               Avalon-MM to SRAM-controller command bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package avm_sram_pkg;

    localparam int AVM_AW  = 19;
    localparam int AVM_DW  = 32;
    localparam int AVM_BEW = AVM_DW / 8;

    typedef struct packed {
        logic               is_wr;
        logic [AVM_AW-1:0]  addr;
        logic [AVM_BEW-1:0] be;
        logic [AVM_DW-1:0]  wdata;
    } avm_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } bridge_state_t;

    function automatic logic is_misaligned(input logic [AVM_AW-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/avm_sram_bridge_fifo.sv
`default_nettype none
// ============================================================================
// Module      : avm_sram_bridge_fifo
// Description : Synchronous command FIFO with registered occupancy count,
//               full/empty flags and same-cycle push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module avm_sram_bridge_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_FULL = DEPTH[c_PTR_W:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Flags come straight from the registered count, so full never depends
    // on the same-cycle pop.
    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/avm_sram_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : avm_sram_cmd_bridge
// Description : Queues Avalon-MM requests and replays them to the SRAM
//               controller with a fixed issue gap; returns read data in
//               order. Optional alignment check: AVM_SRAM_BRIDGE_ALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module avm_sram_cmd_bridge
    import avm_sram_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int ISSUE_GAP    = 2,
    parameter int READ_LATENCY = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [AVM_AW-1:0]  s_address,
    input  logic [AVM_BEW-1:0] s_byteenable,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [AVM_DW-1:0]  s_writedata,
    output logic               s_waitrequest,
    output logic [AVM_DW-1:0]  s_readdata,
    output logic               s_readdatavalid,
    output logic [AVM_AW-1:0]  m_address,
    output logic [AVM_BEW-1:0] m_byteenable,
    output logic               m_read,
    output logic               m_write,
    output logic [AVM_DW-1:0]  m_writedata,
    input  logic [AVM_DW-1:0]  m_readdata
`ifdef AVM_SRAM_BRIDGE_ALIGN_CHK_EN
    ,
    output logic               err
`endif
);

    localparam int c_CMD_W = $bits(avm_cmd_t);
    localparam int c_GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD =
        (ISSUE_GAP > 0) ? c_GAP_W'(ISSUE_GAP - 1) : '0;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_pop_drop;
    logic                    w_gap_done;
    logic                    w_rd_issue;
    logic                    w_ret_zero;
    logic [c_CMD_W-1:0]      w_pop_data;
    avm_cmd_t                w_push_cmd;
    avm_cmd_t                w_pop_cmd;
    bridge_state_t           r_state;
    bridge_state_t           w_state_nxt;
    logic [c_GAP_W-1:0]      r_gap_cnt;
    logic [READ_LATENCY-1:0] r_rd_pipe;

    assign s_waitrequest = w_full;
    assign w_accept      = (s_read | s_write) & ~w_full;
    assign w_pop_cmd     = avm_cmd_t'(w_pop_data);

    // A simultaneous read+write is taken as the write.
    always_comb begin
        w_push_cmd.is_wr = s_write;
        w_push_cmd.addr  = s_address;
        w_push_cmd.be    = s_byteenable;
        w_push_cmd.wdata = s_writedata;
`ifdef AVM_SRAM_BRIDGE_ALIGN_CHK_EN
        w_push_cmd.addr  = s_address;
`else
        w_push_cmd.addr[1:0] = 2'b00;
`endif
    end

    avm_sram_bridge_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_accept),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .full      (w_full),
        .empty     (w_empty)
    );

    // A zero gap lets ISSUE chain straight into the next command.
    assign w_gap_done = ((r_state == ISSUE) && (ISSUE_GAP == 0)) ||
                        ((r_state == GAP) && (r_gap_cnt == '0));

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE, GAP: begin
                if (w_gap_done) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = GAP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ISSUE) begin
                r_gap_cnt <= c_GAP_LOAD;
            end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    // Controller-side outputs are loaded on pop, so they are non-zero only
    // during the ISSUE cycle that follows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
        end else if (w_pop && !w_pop_drop) begin
            m_read       <= ~w_pop_cmd.is_wr;
            m_write      <= w_pop_cmd.is_wr;
            m_address    <= w_pop_cmd.addr;
            m_byteenable <= w_pop_cmd.be;
            m_writedata  <= w_pop_cmd.is_wr ? w_pop_cmd.wdata : '0;
        end else begin
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
        end
    end

`ifdef AVM_SRAM_BRIDGE_ALIGN_CHK_EN
    logic                    r_drop_rd;
    logic [READ_LATENCY-1:0] r_rd_zero;

    assign w_pop_drop = is_misaligned(w_pop_cmd.addr);
    assign w_rd_issue = m_read | r_drop_rd;
    assign w_ret_zero = r_rd_zero[READ_LATENCY-1];

    // Dropped reads still occupy a slot in the return pipe to keep ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_rd <= 1'b0;
            r_rd_zero <= '0;
            err       <= 1'b0;
        end else begin
            r_drop_rd    <= w_pop & w_pop_drop & ~w_pop_cmd.is_wr;
            r_rd_zero[0] <= r_drop_rd;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_zero[i] <= r_rd_zero[i-1];
            end
            if (w_accept && is_misaligned(s_address)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign w_pop_drop = 1'b0;
    assign w_rd_issue = m_read;
    assign w_ret_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pipe       <= '0;
            s_readdatavalid <= 1'b0;
            s_readdata      <= '0;
        end else begin
            r_rd_pipe[0] <= w_rd_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            s_readdatavalid <= r_rd_pipe[READ_LATENCY-1];
            if (r_rd_pipe[READ_LATENCY-1]) begin
                s_readdata <= w_ret_zero ? '0 : m_readdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avm_sram_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_avm_sram_cmd_bridge
// Description : Directed self-checking bench for avm_sram_cmd_bridge with a
//               behavioural SRAM-controller model (fixed 3-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_avm_sram_cmd_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [18:0] s_address;
    logic [3:0]  s_byteenable;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [18:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
`ifdef AVM_SRAM_BRIDGE_ALIGN_CHK_EN
    logic        err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    avm_sram_cmd_bridge #(
        .FIFO_DEPTH   (4),
        .ISSUE_GAP    (2),
        .READ_LATENCY (3)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_address       (s_address),
        .s_byteenable    (s_byteenable),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_readdata      (m_readdata)
`ifdef AVM_SRAM_BRIDGE_ALIGN_CHK_EN
        ,
        .err             (err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller + SRAM model: data for the address seen in cycle I appears
    // on m_readdata in cycle I+3.
    logic [31:0] mem [64];
    logic [31:0] mdl_s1 = '0;
    logic [31:0] mdl_s2 = '0;
    always @(posedge clk) begin
        if (m_write) begin
            for (int b = 0; b < 4; b++) begin
                if (m_byteenable[b]) begin
                    mem[m_address[7:2]][8*b +: 8] <= m_writedata[8*b +: 8];
                end
            end
        end
        mdl_s1     <= mem[m_address[7:2]];
        mdl_s2     <= mdl_s1;
        m_readdata <= mdl_s2;
    end

    int          wr_cyc  [$];
    logic [18:0] wr_addr [$];
    int          rv_cyc  [$];
    logic [31:0] rv_data [$];
    always @(negedge clk) begin
        if (m_write) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(m_address);
        end
        if (s_readdatavalid) begin
            rv_cyc.push_back(cyc);
            rv_data.push_back(s_readdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic req(input logic wr, input logic [18:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int acc);
        int n;
        s_write      = wr;
        s_read       = ~wr;
        s_address    = a;
        s_writedata  = d;
        s_byteenable = be;
        n = 0;
        while (s_waitrequest !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_bound", 32'(n < 40), 32'd1);
        acc = cyc + 1;
        @(negedge clk);
        s_write      = 1'b0;
        s_read       = 1'b0;
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_waitreq"}, 32'(s_waitrequest),   32'd0);
        chk({tag, "_rdvalid"}, 32'(s_readdatavalid), 32'd0);
        chk({tag, "_rdata"},   s_readdata,           32'd0);
        chk({tag, "_m_addr"},  32'(m_address),       32'd0);
        chk({tag, "_m_be"},    32'(m_byteenable),    32'd0);
        chk({tag, "_m_rw"},    32'({m_read, m_write}), 32'd0);
        chk({tag, "_m_wdata"}, m_writedata,          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int dummy;
        int acc [7];

        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset_n      = 1'b0;
        s_address    = '0;
        s_byteenable = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write: m_write for one cycle, one cycle after accept.
        wr_cyc.delete(); wr_addr.delete();
        req(1'b1, 19'h20, 32'hdeadbeef, 4'hF, e0);
        chk("wr1_before_issue", 32'(m_write), 32'd0);
        @(negedge clk);
        chk("wr1_m_write",  32'(m_write),      32'd1);
        chk("wr1_m_read",   32'(m_read),       32'd0);
        chk("wr1_m_addr",   32'(m_address),    32'h20);
        chk("wr1_m_wdata",  m_writedata,       32'hdeadbeef);
        chk("wr1_m_be",     32'(m_byteenable), 32'hF);
        @(negedge clk);
        chk("wr1_after_m_write", 32'(m_write),   32'd0);
        chk("wr1_after_m_addr",  32'(m_address), 32'd0);
        chk("wr1_after_m_wdata", m_writedata,    32'd0);
        repeat (4) @(negedge clk);
        chk("wr1_pulse_count", 32'(wr_cyc.size()), 32'd1);

        // Read-back: valid exactly 5 cycles after accept.
        rv_cyc.delete(); rv_data.delete();
        req(1'b0, 19'h20, 32'h0, 4'hF, e0);
        @(negedge clk);
        chk("rd1_m_read", 32'(m_read),    32'd1);
        chk("rd1_m_addr", 32'(m_address), 32'h20);
        repeat (3) @(negedge clk);
        chk("rd1_valid_early", 32'(s_readdatavalid), 32'd0);
        @(negedge clk);
        chk("rd1_valid",  32'(s_readdatavalid), 32'd1);
        chk("rd1_data",   s_readdata,           32'hdeadbeef);
        @(negedge clk);
        chk("rd1_valid_one_cycle", 32'(s_readdatavalid), 32'd0);
        repeat (3) @(negedge clk);
        chk("rd1_valid_count", 32'(rv_cyc.size()), 32'd1);

        // Burst of 6 back-to-back writes, then a 7th that must stall.
        wr_cyc.delete(); wr_addr.delete();
        for (int i = 0; i < 6; i++) begin
            req(1'b1, 19'(4 * i), 32'h100 + i, 4'hF, acc[i]);
        end
        chk("burst_waitreq_full", 32'(s_waitrequest), 32'd1);
        chk("burst_acc5_b2b",     32'(acc[5] - acc[0]), 32'd5);
        req(1'b1, 19'h18, 32'h106, 4'hF, acc[6]);
        chk("burst_acc6_stalled", 32'(acc[6] - acc[0]), 32'd8);
        repeat (20) @(negedge clk);
        chk("burst_pulse_count", 32'(wr_cyc.size()), 32'd7);
        for (int k = 0; k < 7 && k < wr_cyc.size(); k++) begin
            chk($sformatf("burst_pulse%0d_cycle", k), 32'(wr_cyc[k] - acc[0]), 32'(1 + 3 * k));
            chk($sformatf("burst_pulse%0d_addr", k),  32'(wr_addr[k]),         32'(4 * k));
        end

        // Partial write then two reads returning in order.
        rv_cyc.delete(); rv_data.delete();
        req(1'b1, 19'h10, 32'h12345678, 4'hF, e0);
        req(1'b1, 19'h10, 32'hff000000, 4'h8, dummy);
        req(1'b0, 19'h10, 32'h0,        4'hF, dummy);
        req(1'b0, 19'h04, 32'h0,        4'hF, dummy);
        repeat (16) @(negedge clk);
        chk("order_count", 32'(rv_cyc.size()), 32'd2);
        if (rv_cyc.size() >= 2) begin
            chk("order_first_data",  rv_data[0], 32'hff345678);
            chk("order_second_data", rv_data[1], 32'h00000101);
            chk("order_first_cycle",  32'(rv_cyc[0] - e0), 32'd11);
            chk("order_second_cycle", 32'(rv_cyc[1] - e0), 32'd14);
        end

        // Reset two cycles after a read issues, with writes still queued.
        wr_cyc.delete(); wr_addr.delete();
        rv_cyc.delete(); rv_data.delete();
        req(1'b0, 19'h10, 32'h0, 4'hF, e0);
        req(1'b1, 19'h30, 32'h1, 4'hF, dummy);
        req(1'b1, 19'h34, 32'h2, 4'hF, dummy);
        req(1'b1, 19'h38, 32'h3, 4'hF, dummy);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midreset_no_rdvalid", 32'(rv_cyc.size()), 32'd0);
        chk("midreset_fifo_flush", 32'(wr_cyc.size()), 32'd0);
        req(1'b0, 19'h10, 32'h0, 4'hF, e0);
        repeat (5) @(negedge clk);
        chk("postreset_rd_valid", 32'(s_readdatavalid), 32'd1);
        chk("postreset_rd_data",  s_readdata,           32'hff345678);
        repeat (3) @(negedge clk);

`ifdef AVM_SRAM_BRIDGE_ALIGN_CHK_EN
        chk("align_err_initial", 32'(err), 32'd0);
        wr_cyc.delete(); wr_addr.delete();
        req(1'b1, 19'h13, 32'ha5a5a5a5, 4'hF, e0);
        repeat (6) @(negedge clk);
        chk("align_no_m_write", 32'(wr_cyc.size()), 32'd0);
        chk("align_err_set",    32'(err),           32'd1);
        req(1'b0, 19'h11, 32'h0, 4'hF, e0);
        repeat (5) @(negedge clk);
        chk("align_drop_rd_valid", 32'(s_readdatavalid), 32'd1);
        chk("align_drop_rd_data",  s_readdata,           32'd0);
        chk("align_err_sticky",    32'(err),             32'd1);
        reset_n = 1'b0;
        #1;
        chk("align_err_cleared", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
`else
        // Low address bits are forced to zero in the default build.
        wr_cyc.delete(); wr_addr.delete();
        req(1'b1, 19'h13, 32'ha5a5a5a5, 4'hF, e0);
        @(negedge clk);
        chk("unaligned_m_write", 32'(m_write),   32'd1);
        chk("unaligned_m_addr",  32'(m_address), 32'h10);
        repeat (3) @(negedge clk);
        chk("unaligned_pulse_count", 32'(wr_cyc.size()), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
